// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB first, one bit per clock.
// Optional subtract mode when SERIAL_ADDER_SUB_EN is defined (adds the 'sub' input).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] resr;
  logic [WIDTH-1:0] resr_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [1:0]       fa;
  logic             load;
  logic             step;
  logic             finish;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // The single full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

  // Operand conditioning at load: subtraction is A + ~B + ~borrow_in.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~B;
      c_load = ~Cin;
    end else begin
      b_load = B;
      c_load = Cin;
    end
`else
    b_load = B;
    c_load = Cin;
`endif
  end

  // Cell evaluation on the current LSB pair and held carry.
  always_comb begin
    fa = full_adder(opa[0], opb[0], carry);
  end

  generate
    if (WIDTH == 1) begin : g_w1
      assign resr_next = fa[0];
    end else begin : g_wn
      assign resr_next = {fa[0], resr[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and datapath control strobes.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state = RUN;
          load       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          next_state = DONE;
          finish     = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus handshake/status flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
      busy      <= (next_state == RUN) || (next_state == DONE);
    end
  end

  // Shift datapath; result registers update only on the RUN->DONE step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      resr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      if (load) begin
        opa   <= A;
        opb   <= b_load;
        carry <= c_load;
        cnt   <= '0;
      end else if (step) begin
        opa   <= opa >> 1;
        opb   <= opb >> 1;
        resr  <= resr_next;
        carry <= fa[1];
        cnt   <= cnt + CW'(1);
      end
      // carry here is the carry into the MSB, so carry ^ carry_out is signed overflow
      if (finish) begin
        S    <= resr_next;
        Cout <= fa[1];
        OVF  <= carry ^ fa[1];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8); covers the
// subtract mode as well when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       cout;
  logic       ovf;
  logic       busy;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         lat;
  int         seen;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .Cout(cout), .OVF(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, ".S"}, 32'(s), 32'h0);
    check({tag, ".Cout"}, 32'(cout), 32'h0);
    check({tag, ".OVF"}, 32'(ovf), 32'h0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'h1);
  endtask

  // Present operands for one cycle; returns at the negedge after the handshake edge.
  task automatic start(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
    a = av; b = bv; cin = cv; sub_in = sv; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub_in = 1'b0;
  endtask

  // Cycles from the handshake until out_valid is seen, bounded.
  task automatic wait_done(output int l);
    l = 0;
    while (!out_valid && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".out_valid"}, 32'(out_valid), 32'h1);
    check({tag, ".S"}, 32'(s), 32'(es));
    check({tag, ".Cout"}, 32'(cout), 32'(ec));
    check({tag, ".OVF"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    sub_in = 1'b0; out_ready = 1'b1;

    // 1: reset, before and after the first clock
    #2;
    check_idle_reset("reset_pre");
    @(negedge clk);
    check_idle_reset("reset_post");
    rst = 1'b0;
    @(negedge clk);

    // 2: basic add with signed overflow
    start(8'h5A, 8'h33, 1'b0, 1'b0);
    check("add1.busy_run", 32'(busy), 32'h1);
    check("add1.in_ready_run", 32'(in_ready), 32'h0);
    wait_done(lat);
    check_result("add1", 8'h8D, 1'b0, 1'b1);
    check("add1.in_ready_done", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("add1.in_ready_back", 32'(in_ready), 32'h1);
    check("add1.valid_drop", 32'(out_valid), 32'h0);
    check("add1.busy_idle", 32'(busy), 32'h0);
    check("add1.S_held", 32'(s), 32'h8D);

    // 3: carry wrap, then back-to-back op with carry-in
    start(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    check_result("wrap", 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("wrap.in_ready_back", 32'(in_ready), 32'h1);
    start(8'h7F, 8'h00, 1'b1, 1'b0);
    wait_done(lat);
    check_result("b2b", 8'h80, 1'b0, 1'b1);
    @(negedge clk);

    // 4: backpressure in DONE with an ignored in_valid pulse
    out_ready = 1'b0;
    start(8'h80, 8'h80, 1'b0, 1'b0);
    wait_done(lat);
    check_result("bp", 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
      a = 8'h11; b = 8'h22;
      check("bp.hold_valid", 32'(out_valid), 32'h1);
      check("bp.hold_S", 32'(s), 32'h00);
      check("bp.hold_Cout", 32'(cout), 32'h1);
      check("bp.hold_OVF", 32'(ovf), 32'h1);
      check("bp.hold_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.release_valid", 32'(out_valid), 32'h0);
    check("bp.release_in_ready", 32'(in_ready), 32'h1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp.no_second_result", 32'(seen), 32'h0);
    check("bp.S_kept", 32'(s), 32'h00);
    check("bp.Cout_kept", 32'(cout), 32'h1);

    // 5: reset during the 4th RUN cycle aborts the operation
    start(8'hC3, 8'h3C, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("abort.busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check_idle_reset("abort");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort.no_result", 32'(seen), 32'h0);
    start(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    check_result("after_abort", 8'h02, 1'b0, 1'b0);
    @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    // 6: subtraction
    start(8'h10, 8'h03, 1'b0, 1'b1);
    wait_done(lat);
    check_result("sub1", 8'h0D, 1'b1, 1'b0);
    @(negedge clk);
    start(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(lat);
    check_result("sub2", 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
